// File: rtl/wb_sequencer.sv
// wb_sequencer: in-order write-back sequencer with a 2-entry request queue; optional WB_TIMEOUT_EN wait timeout
module wb_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_src,
    input  logic [4:0] req_dest,
    output logic       req_ready,
    input  logic       md_done,
    input  logic       mem_ready,
    output logic [2:0] ent_write,
    output logic       reg_write,
    output logic [4:0] wb_dest,
    output logic       wb_done,
    output logic       busy,
    output logic       wb_err
);
    typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

    state_t     state, state_nxt;
    logic [7:0] q [2];
    logic       wp, rp;
    logic [1:0] count;
    logic [2:0] cur_src;
    logic [4:0] cur_dest;
    logic [2:0] head_src;
    logic       push, pop, src_ready, drop, to_drop;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("wb_sequencer: TIMEOUT must be at least 2");
    end

    assign req_ready = count != 2'd2;
    assign push      = req_valid && req_ready;
    assign pop       = state == IDLE && count != 2'd0;
    assign head_src  = q[rp][7:5];
    assign src_ready = cur_src == 3'b101 ? mem_ready : md_done;

    assign ent_write = cur_src;
    assign wb_dest   = cur_dest;
    assign wb_done   = state == WRITE;
    assign reg_write = state == WRITE && cur_dest != 5'd0 && !drop;
    assign busy      = count != 2'd0 || state != IDLE;

    // queue storage needs no reset: entries are only read when count says they are valid
    always_ff @(posedge clk)
        if (push)
            q[wp] <= {req_src, req_dest};

    // queue pointers and occupancy
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push)
                wp <= ~wp;
            if (pop)
                rp <= ~rp;
            count <= count + 2'(push) - 2'(pop);
        end

    // state register and the request currently in flight
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state    <= IDLE;
            cur_src  <= 3'd0;
            cur_dest <= 5'd0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                cur_src  <= head_src;
                cur_dest <= q[rp][4:0];
            end
        end

    // HI, LO and load must wait for their producer; everything else writes straight away
    always_comb begin
        state_nxt = state;
        if (state == IDLE && pop)
            state_nxt = head_src inside {3'b010, 3'b011, 3'b101} ? WAIT : WRITE;
        else if (state == WAIT && (src_ready || to_drop))
            state_nxt = WRITE;
        else if (state == WRITE)
            state_nxt = IDLE;
    end

`ifdef WB_TIMEOUT_EN
    logic [7:0] wcnt;

    assign to_drop = state == WAIT && !src_ready && wcnt == 8'(TIMEOUT - 1);

    // wait counter; a timed-out request passes through WRITE with its write suppressed
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wcnt   <= 8'd0;
            drop   <= 1'b0;
            wb_err <= 1'b0;
        end else begin
            wcnt <= state == WAIT ? wcnt + 8'd1 : 8'd0;
            drop <= to_drop;
            if (to_drop)
                wb_err <= 1'b1;
        end
`else
    assign to_drop = 1'b0;
    assign drop    = 1'b0;
    assign wb_err  = 1'b0;
`endif

endmodule
